// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search block.
package sar_pkg;

  // Search controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DONE  = 2'd2
  } sar_state_e;

  // Comparator response encoding, packed as {gt, eq, lt}.
  localparam logic [2:0] RSP_GT = 3'b100;
  localparam logic [2:0] RSP_EQ = 3'b010;
  localparam logic [2:0] RSP_LT = 3'b001;

  // True when exactly one of gt/eq/lt is asserted.
  function automatic logic is_one_hot3(input logic [2:0] rsp);
    return (rsp == RSP_GT) || (rsp == RSP_EQ) || (rsp == RSP_LT);
  endfunction

endpackage

// File: rtl/sar_search_if.sv
// Bus between the search controller and its host/comparator side.
interface sar_search_if #(parameter int WIDTH = 3);

  logic             start;
  logic [WIDTH-1:0] guess;
  logic             guess_valid;
  logic             cmp_valid;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             busy;
  logic             done;
  logic             found;
  logic             error;
  logic [WIDTH-1:0] result;

  // Search controller side.
  modport master (
    input  start, cmp_valid, cmp_gt, cmp_eq, cmp_lt,
    output guess, guess_valid, busy, done, found, error, result
  );

  // Host and comparator side.
  modport slave (
    output start, cmp_valid, cmp_gt, cmp_eq, cmp_lt,
    input  guess, guess_valid, busy, done, found, error, result
  );

endinterface

// File: rtl/sar_search.sv
// Binary search over [0, 2^WIDTH-1] driven by an external three-way comparator.
// Each accepted Gt/Lt narrows the window; Eq, an out-of-bounds answer, a
// malformed response or a runaway probe count ends the search.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input logic          clk,
  input logic          rst,
  sar_search_if.master bus
);

  localparam int                STEP_W     = $clog2(WIDTH + 2);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(WIDTH + 1);
  localparam logic [WIDTH-1:0]  ONE_W      = {{(WIDTH-1){1'b0}}, 1'b1};

  sar_state_e        state_r, state_s;
  logic [WIDTH-1:0]  lo_r, lo_s;
  logic [WIDTH-1:0]  hi_r, hi_s;
  logic [STEP_W-1:0] step_r, step_s;
  logic [WIDTH-1:0]  result_r, result_s;
  logic              found_r, found_s;
  logic              error_r, error_s;

  logic [WIDTH:0]    sum_s;
  logic [WIDTH-1:0]  guess_s;
  logic [2:0]        rsp_s;
  logic [STEP_W-1:0] step_inc_s;
  logic              oob_s;

  // Midpoint is taken from a WIDTH+1 bit sum so lo+hi never overflows.
  assign sum_s      = {1'b0, lo_r} + {1'b0, hi_r};
  assign guess_s    = sum_s[WIDTH:1];
  assign rsp_s      = {bus.cmp_gt, bus.cmp_eq, bus.cmp_lt};
  assign step_inc_s = step_r + STEP_ONE;
  // Moving past the window edge would wrap lo/hi, so it means no match exists.
  assign oob_s      = ((rsp_s == RSP_GT) && (guess_s == hi_r)) ||
                      ((rsp_s == RSP_LT) && (guess_s == lo_r));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-datapath decision.
  always_comb begin
    state_s  = state_r;
    lo_s     = lo_r;
    hi_s     = hi_r;
    step_s   = step_r;
    result_s = result_r;
    found_s  = found_r;
    error_s  = error_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s  = ST_PROBE;
          lo_s     = {WIDTH{1'b0}};
          hi_s     = {WIDTH{1'b1}};
          step_s   = {STEP_W{1'b0}};
          result_s = {WIDTH{1'b0}};
          found_s  = 1'b0;
          error_s  = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PROBE: begin
        if (bus.cmp_valid) begin
          step_s = step_inc_s;
          if (!is_one_hot3(rsp_s)) begin
            state_s  = ST_DONE;
            result_s = guess_s;
            found_s  = 1'b0;
            error_s  = 1'b1;
          end else if (rsp_s == RSP_EQ) begin
            state_s  = ST_DONE;
            result_s = guess_s;
            found_s  = 1'b1;
            error_s  = 1'b0;
          end else if (oob_s) begin
            state_s  = ST_DONE;
            result_s = guess_s;
            found_s  = 1'b0;
            error_s  = 1'b0;
          end else if (step_inc_s == STEP_LIMIT) begin
            // Unreachable with a consistent comparator; stops a runaway search.
            state_s  = ST_DONE;
            result_s = guess_s;
            found_s  = 1'b0;
            error_s  = 1'b1;
          end else if (rsp_s == RSP_GT) begin
            lo_s = guess_s + ONE_W;
          end else begin
            hi_s = guess_s - ONE_W;
          end
        end else begin
          state_s = ST_PROBE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Search window, probe counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_r     <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b1}};
      step_r   <= {STEP_W{1'b0}};
      result_r <= {WIDTH{1'b0}};
      found_r  <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      lo_r     <= lo_s;
      hi_r     <= hi_s;
      step_r   <= step_s;
      result_r <= result_s;
      found_r  <= found_s;
      error_r  <= error_s;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    bus.guess_valid = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        bus.guess_valid = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
      end
      ST_PROBE: begin
        bus.guess_valid = 1'b1;
        bus.busy        = 1'b1;
        bus.done        = 1'b0;
      end
      ST_DONE: begin
        bus.guess_valid = 1'b0;
        bus.busy        = 1'b1;
        bus.done        = 1'b1;
      end
      default: begin
        bus.guess_valid = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
      end
    endcase
  end

  assign bus.guess  = guess_s;
  assign bus.result = result_r;
  assign bus.found  = found_r;
  assign bus.error  = error_r;

endmodule
